// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Forwarding and load-use hazard unit for the ID stage of a RISC-V pipeline.
//   Each ID source register is compared against the destinations of the
//   instructions now in EX and MEM. The resulting per-source bypass select is
//   registered into the ID/EX boundary. A load-use hazard stalls IF/ID and
//   bubbles ID/EX for LOAD_LAT cycles.
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   id_rs_i        ID source addresses, source i at [i*AW +: AW]
//   id_rs_used_i   bit i set: source i is read by the ID instruction
//   ex_rd_i        destination of the EX instruction
//   ex_reg_we_i    EX instruction writes the register file
//   ex_jump_t_i    00 none, 01 JAL, 10 JALR, 11 none
//   ex_is_load_i   EX instruction is a load
//   mem_rd_i       destination of the MEM instruction
//   mem_reg_we_i   MEM instruction writes the register file
//   mem_jump_t_i   same encoding as ex_jump_t_i
//   flush_i        kill the ID instruction and cancel any stall
//   hold_i         global freeze, all state holds
//   fwd_sel_o      registered bypass select per source, 3 bits each
//   stall_o        freeze PC and IF/ID this cycle
//   bubble_o       load a NOP into ID/EX this cycle
module fwd_hazard_unit #(
   parameter int unsigned NUM_SRC  = 2,
   parameter int unsigned AW       = 5,
   parameter int unsigned LOAD_LAT = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [NUM_SRC*AW-1:0]  id_rs_i,
   input  logic [NUM_SRC-1:0]     id_rs_used_i,
   input  logic [AW-1:0]          ex_rd_i,
   input  logic                   ex_reg_we_i,
   input  logic [1:0]             ex_jump_t_i,
   input  logic                   ex_is_load_i,
   input  logic [AW-1:0]          mem_rd_i,
   input  logic                   mem_reg_we_i,
   input  logic [1:0]             mem_jump_t_i,
   input  logic                   flush_i,
   input  logic                   hold_i,
   output logic [NUM_SRC*3-1:0]   fwd_sel_o,
   output logic                   stall_o,
   output logic                   bubble_o
);

   localparam logic [0:0] StIdle  = 1'b0;
   localparam logic [0:0] StStall = 1'b1;

   localparam logic [2:0] SelRegFile = 3'b000;
   localparam logic [2:0] SelMemPc   = 3'b001;
   localparam logic [2:0] SelWbPc    = 3'b010;
   localparam logic [2:0] SelMemAlu  = 3'b011;
   localparam logic [2:0] SelWbRes   = 3'b100;

   // The first bubble is issued from StIdle, so StStall covers the remainder.
   localparam logic [2:0] CntInit = 3'(LOAD_LAT - 1);

   logic [0:0]           state_q, state_d;
   logic [2:0]           cnt_q, cnt_d;
   logic [NUM_SRC*3-1:0] fwd_q, fwd_d;
   logic [NUM_SRC*3-1:0] sel_calc;
   logic                 hazard;
   logic                 stall;
   logic                 ex_jump, mem_jump;
   logic [AW-1:0]        rs;
   logic                 ex_hit, mem_hit;

   // Bypass select per source; the EX producer is younger and wins over MEM.
   always_comb begin
      sel_calc = '0;
      hazard   = 1'b0;
      rs       = '0;
      ex_hit   = 1'b0;
      mem_hit  = 1'b0;
      ex_jump  = (ex_jump_t_i == 2'b01) || (ex_jump_t_i == 2'b10);
      mem_jump = (mem_jump_t_i == 2'b01) || (mem_jump_t_i == 2'b10);
      for (int i = 0; i < NUM_SRC; i++) begin
         rs      = id_rs_i[i*AW +: AW];
         ex_hit  = id_rs_used_i[i] && ex_reg_we_i && (rs == ex_rd_i) && (rs != '0);
         mem_hit = id_rs_used_i[i] && mem_reg_we_i && (rs == mem_rd_i) && (rs != '0);
         if (ex_hit && ex_is_load_i) begin
            hazard = 1'b1;
         end
         if (ex_hit) begin
            if (ex_jump) begin
               sel_calc[i*3 +: 3] = SelMemPc;
            end else if (!ex_is_load_i) begin
               sel_calc[i*3 +: 3] = SelMemAlu;
            end
         end else if (mem_hit) begin
            sel_calc[i*3 +: 3] = mem_jump ? SelWbPc : SelWbRes;
         end else begin
            sel_calc[i*3 +: 3] = SelRegFile;
         end
      end
   end

   // Gated by reset so no bubble leaks out while the unit is held in reset.
   assign stall = rst_ni && !flush_i &&
                  (((state_q == StIdle) && hazard) || (state_q == StStall));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fwd_d   = fwd_q;
      if (flush_i) begin
         state_d = StIdle;
         cnt_d   = 3'd0;
         fwd_d   = '0;
      end else if (!hold_i) begin
         // A bubble carries no bypass.
         fwd_d = stall ? '0 : sel_calc;
         if (state_q == StIdle) begin
            if (hazard && (LOAD_LAT > 1)) begin
               state_d = StStall;
               cnt_d   = CntInit;
            end
         end else begin
            if (cnt_q == 3'd1) begin
               state_d = StIdle;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         cnt_q   <= 3'd0;
         fwd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fwd_q   <= fwd_d;
      end
   end

   assign fwd_sel_o = fwd_q;
   assign stall_o   = stall;
   assign bubble_o  = stall;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two instances (LOAD_LAT 1 and 3) share stimulus.
// A remaining-bubble-count model predicts every output on every negedge;
// directed sequences pin the model with literal expectations.
module tb_fwd_hazard_unit;

   localparam int AW = 5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  id_rs;
   logic [1:0]  used;
   logic [4:0]  ex_rd, mem_rd;
   logic        ex_we, ex_ld, mem_we, flush, hold;
   logic [1:0]  ex_jt, mem_jt;

   logic [5:0]  fwd_a, fwd_b;
   logic        st_a, st_b, bu_a, bu_b;

   int checks = 0;
   int errors = 0;
   bit en = 1'b0;

   always #5 clk = ~clk;

   fwd_hazard_unit #(.NUM_SRC(2), .AW(AW), .LOAD_LAT(1)) u_a (
      .clk_i(clk), .rst_ni(rst_n), .id_rs_i(id_rs), .id_rs_used_i(used),
      .ex_rd_i(ex_rd), .ex_reg_we_i(ex_we), .ex_jump_t_i(ex_jt), .ex_is_load_i(ex_ld),
      .mem_rd_i(mem_rd), .mem_reg_we_i(mem_we), .mem_jump_t_i(mem_jt),
      .flush_i(flush), .hold_i(hold), .fwd_sel_o(fwd_a), .stall_o(st_a), .bubble_o(bu_a)
   );

   fwd_hazard_unit #(.NUM_SRC(2), .AW(AW), .LOAD_LAT(3)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .id_rs_i(id_rs), .id_rs_used_i(used),
      .ex_rd_i(ex_rd), .ex_reg_we_i(ex_we), .ex_jump_t_i(ex_jt), .ex_is_load_i(ex_ld),
      .mem_rd_i(mem_rd), .mem_reg_we_i(mem_we), .mem_jump_t_i(mem_jt),
      .flush_i(flush), .hold_i(hold), .fwd_sel_o(fwd_b), .stall_o(st_b), .bubble_o(bu_b)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit ex_match(input int i);
      logic [4:0] r;
      r = id_rs[i*AW +: AW];
      return used[i] && ex_we && (r == ex_rd) && (r != 0);
   endfunction

   function automatic bit mem_match(input int i);
      logic [4:0] r;
      r = id_rs[i*AW +: AW];
      return used[i] && mem_we && (r == mem_rd) && (r != 0);
   endfunction

   function automatic int ref_code(input int i);
      if (ex_match(i)) begin
         if (ex_jt == 2'd1 || ex_jt == 2'd2) return 1;
         if (ex_ld) return 0;
         return 3;
      end
      if (mem_match(i)) return (mem_jt == 2'd1 || mem_jt == 2'd2) ? 2 : 4;
      return 0;
   endfunction

   function automatic bit ref_haz();
      return (ex_match(0) && ex_ld) || (ex_match(1) && ex_ld);
   endfunction

   function automatic logic [5:0] ref_codes();
      return {3'(ref_code(1)), 3'(ref_code(0))};
   endfunction

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   // left[k]: bubbles still owed after the current cycle's.
   int         left[2] = '{0, 0};
   logic [5:0] mfwd[2] = '{6'd0, 6'd0};

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            left[k] <= 0;
            mfwd[k] <= '0;
         end else if (flush) begin
            left[k] <= 0;
            mfwd[k] <= '0;
         end else if (!hold) begin
            if (left[k] > 0) begin
               left[k] <= left[k] - 1;
               mfwd[k] <= '0;
            end else if (ref_haz()) begin
               left[k] <= lat_of(k) - 1;
               mfwd[k] <= '0;
            end else begin
               mfwd[k] <= ref_codes();
            end
         end
      end
   end

   always @(negedge clk) begin
      if (en) begin
         logic e0, e1;
         e0 = rst_n && !flush && (left[0] > 0 || ref_haz());
         e1 = rst_n && !flush && (left[1] > 0 || ref_haz());
         chk("m_stall_a", 32'(st_a), 32'(e0));
         chk("m_bubble_a", 32'(bu_a), 32'(e0));
         chk("m_fwd_a", 32'(fwd_a), 32'(mfwd[0]));
         chk("m_stall_b", 32'(st_b), 32'(e1));
         chk("m_bubble_b", 32'(bu_b), 32'(e1));
         chk("m_fwd_b", 32'(fwd_b), 32'(mfwd[1]));
      end
   end

   // ---------------- stimulus ----------------
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      id_rs = '0; used = '0; ex_rd = '0; ex_we = 0; ex_jt = '0; ex_ld = 0;
      mem_rd = '0; mem_we = 0; mem_jt = '0; flush = 0; hold = 0;
   endtask

   // Load into rd 7 in EX, consumed by rs2.
   task automatic set_load_hazard();
      clr();
      id_rs[9:5] = 5'd7; used = 2'b10; ex_rd = 5'd7; ex_we = 1; ex_ld = 1;
   endtask

   task automatic load_to_mem();
      ex_we = 0; ex_ld = 0; mem_rd = 5'd7; mem_we = 1;
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      clr();
      nxt();
      en = 1'b1;
      repeat (2) nxt();
      chk("rst_fwd", 32'(fwd_a), 0);
      chk("rst_stall", 32'(st_a), 0);
      rst_n = 1'b1;

      // Test 1: rs1 from EX ALU, rs2 from MEM
      clr();
      id_rs[4:0] = 5'd5; id_rs[9:5] = 5'd6; used = 2'b11;
      ex_rd = 5'd5; ex_we = 1; mem_rd = 5'd6; mem_we = 1;
      @(negedge clk);
      chk("t1_stall", 32'(st_a), 0);
      nxt();
      chk("t1_fwd", 32'(fwd_a), 32'(6'b100_011));

      // Test 2: x0 and disabled matches
      clr();
      ex_we = 1; used = 2'b01;
      nxt();
      chk("t2_x0", 32'(fwd_a[2:0]), 0);
      id_rs[4:0] = 5'd9; ex_rd = 5'd9; ex_we = 0;
      nxt();
      chk("t2_we0", 32'(fwd_a[2:0]), 0);
      ex_we = 1; used = 2'b00;
      nxt();
      chk("t2_unused", 32'(fwd_a[2:0]), 0);

      // Test 3: jump link values
      clr();
      id_rs[4:0] = 5'd1; used = 2'b01; ex_rd = 5'd1; ex_we = 1; ex_jt = 2'b01;
      nxt();
      chk("t3_ex_jal", 32'(fwd_a[2:0]), 1);
      ex_we = 0; mem_rd = 5'd1; mem_we = 1; mem_jt = 2'b10;
      nxt();
      chk("t3_mem_jalr", 32'(fwd_a[2:0]), 2);
      ex_we = 1;
      nxt();
      chk("t3_both", 32'(fwd_a[2:0]), 1);

      // Test 4: LOAD_LAT=1 load-use
      set_load_hazard();
      @(negedge clk);
      chk("t4_stall", 32'(st_a), 1);
      chk("t4_bubble", 32'(bu_a), 1);
      nxt();
      chk("t4_fwd0", 32'(fwd_a), 0);
      load_to_mem();
      @(negedge clk);
      chk("t4_release", 32'(st_a), 0);
      nxt();
      chk("t4_wb", 32'(fwd_a[5:3]), 4);
      clr();
      repeat (4) nxt();

      // Test 5: LOAD_LAT=3 with a 2-cycle hold midway
      set_load_hazard();
      n = 0;
      for (int c = 0; c < 5; c++) begin
         hold = (c == 2 || c == 3);
         @(negedge clk);
         if (st_b) n++;
         nxt();
      end
      hold = 0;
      load_to_mem();
      @(negedge clk);
      chk("t5_end", 32'(st_b), 0);
      chk("t5_count", 32'(n), 5);
      nxt();
      chk("t5_wb", 32'(fwd_b[5:3]), 4);
      clr();
      repeat (4) nxt();

      // Test 6: flush during stall
      set_load_hazard();
      @(negedge clk);
      chk("t6_stall", 32'(st_b), 1);
      nxt();
      flush = 1;
      @(negedge clk);
      chk("t6_flush_stall", 32'(st_b), 0);
      nxt();
      chk("t6_flush_fwd", 32'(fwd_b), 0);
      clr();
      @(negedge clk);
      chk("t6_idle", 32'(st_b), 0);
      nxt();

      // Reset during stall
      set_load_hazard();
      nxt();
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_stall_b", 32'(st_b), 0);
      chk("t6_rst_bubble_b", 32'(bu_b), 0);
      chk("t6_rst_stall_a", 32'(st_a), 0);
      chk("t6_rst_fwd_b", 32'(fwd_b), 0);
      clr();
      nxt();
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_rst_idle", 32'(st_b), 0);

      // Randomized traffic on a small register window to provoke matches
      for (int c = 0; c < 3000; c++) begin
         nxt();
         rst_n  = ($urandom_range(0, 199) != 0);
         id_rs  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         used   = 2'($urandom);
         ex_rd  = 5'($urandom_range(0, 7));
         ex_we  = ($urandom_range(0, 3) != 0);
         ex_jt  = 2'($urandom);
         ex_ld  = ($urandom_range(0, 2) == 0);
         mem_rd = 5'($urandom_range(0, 7));
         mem_we = ($urandom_range(0, 3) != 0);
         mem_jt = 2'($urandom);
         flush  = ($urandom_range(0, 15) == 0);
         hold   = ($urandom_range(0, 7) == 0);
      end
      nxt();
      en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
